zeroriscy_mem_arbiter: RTL and testbench
========================================

# zeroriscy_mem_arbiter

Two-to-one memory arbiter that shares a single OBI-style memory port between the zeroriscy_core instruction-fetch and load/store interfaces. It selects one requester per cycle, forwards address/control to memory, and tracks outstanding transactions in an in-order ID FIFO so each response returns to the requester that issued it. Data accesses have priority. A starvation counter guarantees forward progress for instruction fetch. The block sits between zeroriscy_core and a single-ported instruction/data RAM.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- MAX_OUTSTANDING, 2, depth of the response-routing FIFO (≥1)
- STARVE_LIMIT, 4, consecutive instr-losing grants before instr gets priority (≥1)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- instr_req_i / instr_addr_i  in  1 / ADDR_WIDTH  fetch request, address
- instr_gnt_o / instr_rvalid_o  out  1 / 1  fetch grant, response valid
- instr_rdata_o  out  DATA_WIDTH  fetch read data
- data_req_i / data_we_i  in  1 / 1  LSU request, write enable
- data_addr_i / data_be_i / data_wdata_i  in  ADDR_WIDTH / DATA_WIDTH/8 / DATA_WIDTH  LSU address, byte enables, write data
- data_gnt_o / data_rvalid_o / data_err_o  out  1 / 1 / 1  LSU grant, response valid, bus error
- data_rdata_o  out  DATA_WIDTH  LSU read data
- mem_req_o / mem_we_o  out  1 / 1  memory request, write enable
- mem_addr_o / mem_be_o / mem_wdata_o  out  ADDR_WIDTH / DATA_WIDTH/8 / DATA_WIDTH  memory address, byte enables, write data
- mem_gnt_i / mem_rvalid_i / mem_err_i  in  1 / 1 / 1  memory grant, response valid, error
- mem_rdata_i  in  DATA_WIDTH  memory read data
- busy_o  out  1  any transaction outstanding
- protocol_err_o  out  1  sticky: mem_rvalid_i seen with FIFO empty

## Operation
- Issue allowed only when FIFO count < MAX_OUTSTANDING; otherwise mem_req_o=0 and both gnt=0.
- Selection (combinational, registered priority): if only one requester active, it is selected. If both are active, data is selected unless starve_cnt == STARVE_LIMIT, in which case instr is selected.
- mem_* driven from selected requester. Instr path forces mem_we_o=0, mem_be_o=all ones, mem_wdata_o=0.
- Selected requester's gnt = mem_gnt_i. The unselected requester's gnt=0.
- Push: on mem_req_o && mem_gnt_i, push ID (0=instr, 1=data).
- Pop: on mem_rvalid_i with FIFO non-empty, pop head and route rvalid/rdata to the head ID. data_err_o = mem_err_i on data responses. mem_err_i on instr responses is dropped.
- Push and pop may happen in the same cycle. Full is evaluated on the registered count only (no bypass), so a full FIFO blocks issue even while popping.
- rvalid with FIFO empty: no response forwarded, protocol_err_o set until reset.
- starve_cnt (clog2(STARVE_LIMIT+1) bits):
  - increments, saturating at STARVE_LIMIT, when data is granted while instr_req_i=1;
  - clears when instr is granted;
  - holds otherwise.
- busy_o = (count != 0).
- rdata outputs pass mem_rdata_i through unconditionally. Only the rvalid outputs are qualified.

## Timing
- Request→mem_req_o, and mem_gnt_i→*_gnt_o: combinational, zero latency.
- mem_rvalid_i→*_rvalid_o: combinational, routed by FIFO head (registered).
- Memory must return rvalid no earlier than the cycle after gnt, and responses in order.
- Reset (asynchronous, mid-operation included):
  - FIFO empty, count=0, starve_cnt=0, protocol_err_o=0;
  - mem_req_o, all gnt and rvalid outputs forced 0 while rst_i=1;
  - busy_o=0.
  - Responses to transactions in flight at reset arrive with an empty FIFO and set protocol_err_o.
- Requesters must hold req/addr stable until gnt; the arbiter never re-selects while a granted beat is pending (grant is single-cycle).

## Test plan
- Reset, then instr_req_i=1 at 0x100 with mem_gnt_i=1 → mem_addr_o=0x100, mem_be_o=4'hF, instr_gnt_o=1. Next-cycle mem_rvalid_i with rdata 0xDEADBEEF → instr_rvalid_o=1, instr_rdata_o=0xDEADBEEF, data_rvalid_o=0.
- Both requesting every cycle, mem_gnt_i=1, immediate responses → data granted 4 times, instr granted on the 5th, pattern repeats (STARVE_LIMIT=4).
- MAX_OUTSTANDING=2, gnt=1, rvalid withheld → two grants, then mem_req_o=0 and gnts=0 until the first rvalid. busy_o=1 throughout.
- Interleaved data write, instr read, data read → responses route data, instr, data in order. mem_err_i=1 on the 3rd response → data_err_o=1 only on that beat.
- mem_rvalid_i pulse with nothing outstanding → no rvalid output, protocol_err_o=1 and sticky until rst_i.
- rst_i asserted with 2 outstanding → all outputs 0 immediately (asynchronous). After release, a late mem_rvalid_i sets protocol_err_o.

Source files
------------

// File: rtl/zeroriscy_mem_arbiter.sv
// Two-to-one OBI memory arbiter: instruction fetch and load/store share one memory port.
// Responses return in order and are routed by a small FIFO of requester IDs.
module zeroriscy_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      instr_req_i,
    input  logic [ADDR_WIDTH-1:0]     instr_addr_i,
    output logic                      instr_gnt_o,
    output logic                      instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]     instr_rdata_o,

    input  logic                      data_req_i,
    input  logic                      data_we_i,
    input  logic [ADDR_WIDTH-1:0]     data_addr_i,
    input  logic [DATA_WIDTH/8-1:0]   data_be_i,
    input  logic [DATA_WIDTH-1:0]     data_wdata_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    output logic                      data_err_o,
    output logic [DATA_WIDTH-1:0]     data_rdata_o,

    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic                      mem_err_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,

    output logic                      busy_o,
    output logic                      protocol_err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STARVE_LIMIT);

    logic [MAX_OUTSTANDING-1:0] id_mem;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;
    logic [ST_W-1:0]            starve_cnt;
    logic                       prot_err;

    logic can_issue;
    logic sel_data;
    logic push;
    logic pop;
    logic head_id;

    // Handshake: a request transfers on the cycle mem_req_o && mem_gnt_i are both
    // high; exactly one response (mem_rvalid_i) follows later, in issue order.
    // Full is judged on the registered count only, so a pop never frees a slot
    // for an issue in the same cycle.
    always_comb begin
        can_issue = (count < MAX_CNT);
        sel_data  = data_req_i && !(instr_req_i && (starve_cnt == ST_MAX));
        mem_req_o = !rst_i && can_issue && (instr_req_i || data_req_i);
        push      = mem_req_o && mem_gnt_i;
        pop       = !rst_i && mem_rvalid_i && (count != '0);
        head_id   = id_mem[rd_ptr];
    end

    always_comb begin
        mem_we_o    = sel_data && data_we_i;
        mem_addr_o  = sel_data ? data_addr_i : instr_addr_i;
        mem_be_o    = sel_data ? data_be_i : '1;
        mem_wdata_o = sel_data ? data_wdata_i : '0;

        instr_gnt_o = mem_req_o && !sel_data && mem_gnt_i;
        data_gnt_o  = mem_req_o && sel_data && mem_gnt_i;

        instr_rvalid_o = pop && !head_id;
        data_rvalid_o  = pop && head_id;
        data_err_o     = pop && head_id && mem_err_i;
        instr_rdata_o  = mem_rdata_i;
        data_rdata_o   = mem_rdata_i;

        busy_o         = (count != '0);
        protocol_err_o = prot_err;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_mem <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                id_mem[wr_ptr] <= sel_data;
                wr_ptr         <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Counts data wins that happened while fetch was waiting; a fetch grant clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
            prot_err   <= 1'b0;
        end else begin
            if (push) begin
                if (!sel_data) begin
                    starve_cnt <= '0;
                end else if (instr_req_i && (starve_cnt != ST_MAX)) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end
            if (mem_rvalid_i && (count == '0)) begin
                prot_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_zeroriscy_mem_arbiter.sv
// Bench for zeroriscy_mem_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based reference model.
module tb_zeroriscy_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXO = 2;
    localparam int SL   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          instr_req = 1'b0;
    logic [AW-1:0] instr_addr = '0;
    logic          instr_gnt, instr_rvalid;
    logic [DW-1:0] instr_rdata;
    logic          data_req = 1'b0, data_we = 1'b0;
    logic [AW-1:0] data_addr = '0;
    logic [BW-1:0] data_be = '0;
    logic [DW-1:0] data_wdata = '0;
    logic          data_gnt, data_rvalid, data_err;
    logic [DW-1:0] data_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy, protocol_err;

    int checks = 0;
    int errors = 0;

    // Reference model: IDs of outstanding beats (0 = fetch, 1 = data), starvation count, sticky error.
    logic [0:0] exp_q[$];
    int         starve_m = 0;
    logic       prot_m = 1'b0;
    logic       i_gnt_seen = 1'b0;
    logic       d_gnt_seen = 1'b0;

    always #5 clk = ~clk;

    zeroriscy_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr),
        .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
        .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
        .data_be_i(data_be), .data_wdata_i(data_wdata),
        .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid), .data_err_o(data_err),
        .data_rdata_o(data_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_err_i(mem_err), .mem_rdata_i(mem_rdata),
        .busy_o(busy), .protocol_err_o(protocol_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Compare process: outputs are settled mid-cycle; the model then advances to the next edge.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_mem_req", mem_req, 0);
            check("rst_instr_gnt", instr_gnt, 0);
            check("rst_data_gnt", data_gnt, 0);
            check("rst_instr_rvalid", instr_rvalid, 0);
            check("rst_data_rvalid", data_rvalid, 0);
            check("rst_busy", busy, 0);
            check("rst_protocol_err", protocol_err, 0);
            exp_q.delete();
            starve_m   = 0;
            prot_m     = 1'b0;
            i_gnt_seen = 1'b0;
            d_gnt_seen = 1'b0;
        end else begin
            bit   full, pick_d, e_req, e_ig, e_dg, was_empty, do_pop, e_iv, e_dv;
            logic head;
            full      = exp_q.size() >= MAXO;
            pick_d    = data_req && !(instr_req && starve_m == SL);
            e_req     = !full && (instr_req || data_req);
            e_ig      = e_req && !pick_d && mem_gnt;
            e_dg      = e_req && pick_d && mem_gnt;
            was_empty = exp_q.size() == 0;
            do_pop    = mem_rvalid && !was_empty;
            head      = do_pop ? exp_q[0] : 1'b0;
            e_iv      = do_pop && head == 1'b0;
            e_dv      = do_pop && head == 1'b1;

            check("mem_req", mem_req, e_req);
            check("instr_gnt", instr_gnt, e_ig);
            check("data_gnt", data_gnt, e_dg);
            if (e_req) begin
                check("mem_addr", mem_addr, pick_d ? data_addr : instr_addr);
                check("mem_we", mem_we, pick_d && data_we);
                check("mem_be", mem_be, pick_d ? data_be : {BW{1'b1}});
                check("mem_wdata", mem_wdata, pick_d ? data_wdata : '0);
            end
            check("instr_rvalid", instr_rvalid, e_iv);
            check("data_rvalid", data_rvalid, e_dv);
            if (e_dv) check("data_err", data_err, mem_err);
            check("instr_rdata", instr_rdata, mem_rdata);
            check("data_rdata", data_rdata, mem_rdata);
            check("busy", busy, !was_empty);
            check("protocol_err", protocol_err, prot_m);

            if (do_pop) void'(exp_q.pop_front());
            if (mem_rvalid && was_empty) prot_m = 1'b1;
            if (e_ig) begin
                exp_q.push_back(1'b0);
                starve_m = 0;
            end
            if (e_dg) begin
                exp_q.push_back(1'b1);
                if (instr_req && starve_m < SL) starve_m++;
            end
            i_gnt_seen = instr_gnt;
            d_gnt_seen = data_gnt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_req = 0; data_req = 0; data_we = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
    endtask

    task automatic reset_dut();
        tick();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic random_cycle();
        if (!instr_req || i_gnt_seen) begin
            instr_req  = ($urandom_range(0, 2) != 0);
            instr_addr = AW'($urandom_range(0, 1023)) << 2;
        end
        if (!data_req || d_gnt_seen) begin
            data_req   = ($urandom_range(0, 2) != 0);
            data_we    = 1'($urandom_range(0, 1));
            data_addr  = AW'($urandom_range(0, 1023)) << 2;
            data_be    = BW'($urandom_range(1, 15));
            data_wdata = $urandom;
        end
        mem_gnt    = ($urandom_range(0, 3) != 0);
        mem_rvalid = (exp_q.size() != 0) && ($urandom_range(0, 1) == 1);
        mem_err    = ($urandom_range(0, 7) == 0);
        mem_rdata  = $urandom;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Single fetch and its response.
        instr_req = 1; instr_addr = 32'h100; mem_gnt = 1;
        #1;
        check("t1_mem_req", mem_req, 1);
        check("t1_mem_addr", mem_addr, 32'h100);
        check("t1_mem_be", mem_be, 4'hF);
        check("t1_instr_gnt", instr_gnt, 1);
        tick();
        instr_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        #1;
        check("t1_instr_rvalid", instr_rvalid, 1);
        check("t1_instr_rdata", instr_rdata, 32'hDEADBEEF);
        check("t1_data_rvalid", data_rvalid, 0);

        // Stray response with nothing outstanding.
        tick();
        mem_rvalid = 1;
        #1;
        check("pe_instr_rvalid", instr_rvalid, 0);
        check("pe_data_rvalid", data_rvalid, 0);
        tick();
        mem_rvalid = 0;
        repeat (3) tick();
        check("pe_sticky", protocol_err, 1);
        reset_dut();
        #1 check("pe_cleared", protocol_err, 0);

        // Both requesting continuously: four data grants then one fetch grant.
        instr_req = 1; data_req = 1; mem_gnt = 1;
        for (int k = 0; k < 10; k++) begin
            mem_rvalid = (k > 0);
            #1;
            check("st_data_gnt", data_gnt, (k % 5) != 4);
            check("st_instr_gnt", instr_gnt, (k % 5) == 4);
            if (k > 0) check("st_data_rvalid", data_rvalid, ((k - 1) % 5) != 4);
            tick();
        end
        instr_req = 0; data_req = 0; mem_gnt = 0; mem_rvalid = 1;
        tick();
        mem_rvalid = 0;
        reset_dut();

        // Outstanding limit: two grants, blocked while full, including the popping cycle.
        instr_req = 1; instr_addr = 32'h200; mem_gnt = 1;
        for (int k = 0; k < 6; k++) begin
            mem_rvalid = (k == 4);
            #1;
            check("mo_mem_req", mem_req, (k < 2) || (k == 5));
            check("mo_instr_gnt", instr_gnt, (k < 2) || (k == 5));
            check("mo_busy", busy, k != 0);
            check("mo_instr_rvalid", instr_rvalid, k == 4);
            tick();
        end

        // Asynchronous reset with two beats outstanding, then a late response.
        mem_rvalid = 1;
        #1 rst = 1;
        #1;
        check("ar_mem_req", mem_req, 0);
        check("ar_instr_gnt", instr_gnt, 0);
        check("ar_instr_rvalid", instr_rvalid, 0);
        check("ar_busy", busy, 0);
        check("ar_protocol_err", protocol_err, 0);
        tick();
        rst = 0; instr_req = 0; mem_gnt = 0; mem_rvalid = 1;
        #1;
        check("ar_late_rvalid", instr_rvalid, 0);
        tick();
        mem_rvalid = 0;
        #1 check("ar_protocol_err_set", protocol_err, 1);
        reset_dut();

        // Data write, fetch, data read: in-order routing and error only on the data beat.
        data_req = 1; data_we = 1; data_addr = 32'h300; data_be = 4'h3;
        data_wdata = 32'h12345678; mem_gnt = 1;
        #1;
        check("er_mem_we", mem_we, 1);
        check("er_mem_be", mem_be, 4'h3);
        check("er_mem_wdata", mem_wdata, 32'h12345678);
        check("er_data_gnt", data_gnt, 1);
        tick();
        data_req = 0; instr_req = 1; instr_addr = 32'h104; mem_rvalid = 1; mem_err = 0;
        #1;
        check("er_rsp1_data", data_rvalid, 1);
        check("er_rsp1_err", data_err, 0);
        check("er_instr_gnt", instr_gnt, 1);
        check("er_instr_we", mem_we, 0);
        check("er_instr_wdata", mem_wdata, 0);
        tick();
        instr_req = 0; data_req = 1; data_we = 0; data_addr = 32'h304; data_be = 4'hF;
        mem_rvalid = 1; mem_err = 1;
        #1;
        check("er_rsp2_instr", instr_rvalid, 1);
        check("er_rsp2_data", data_rvalid, 0);
        check("er_rsp2_err", data_err, 0);
        check("er_data_gnt2", data_gnt, 1);
        tick();
        data_req = 0; mem_rvalid = 1; mem_err = 1;
        #1;
        check("er_rsp3_data", data_rvalid, 1);
        check("er_rsp3_err", data_err, 1);
        check("er_rsp3_instr", instr_rvalid, 0);
        tick();
        mem_rvalid = 0; mem_err = 0;
        reset_dut();

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            random_cycle();
            tick();
        end
        idle_inputs();
        for (int n = 0; n < 10; n++) begin
            mem_rvalid = (exp_q.size() != 0);
            tick();
        end
        mem_rvalid = 0;
        tick();
        check("drain_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
